replica_array: RTL and testbench

- Parametrised successor of the single-replica tile: instantiates REPLICA_NUM replica tiles as a neighbour chain.
- Adds an internal iteration sequencer that drives every per-tile command: opt, distance, metropolis and exchange.
- Alternates even/odd replica-exchange pairing between iterations and counts iterations to completion.
- Sits between the host register block and the replica tiles. The host only loads the distance table, supplies a seed and starts a run.

---
 rtl/replica_pkg.sv | 32 +++
 rtl/replica_seq.sv | 86 ++++++++
 rtl/replica_tile.sv | 59 +++++
 rtl/replica_array.sv | 65 ++++++
 tb/tb_replica_array.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/replica_pkg.sv
// replica_pkg: shared types, command encodings and role helpers for the replica array
package replica_pkg;
    localparam int CITY_NUM = 8;
    localparam int CITY_NUM_LOG = 3;
    localparam int DIST_W = 16;
    localparam int TOTAL_W = 24;
    typedef logic [DIST_W-1:0] distance_data_t;
    typedef logic [TOTAL_W-1:0] total_data_t;
    typedef logic [CITY_NUM_LOG*2-1:0] distance_addr_t;
    typedef enum logic [2:0] {IDLE, SEED, OPT, DIST, METRO, EXCH, DONE} state_t;
    typedef enum logic [1:0] {SELF, PREV, FOLW} role_t;
    typedef enum logic {OPT_NOP, OPT_RUN} opt_command_t;
    typedef enum logic {DIST_NOP, DIST_RUN} distance_command_t;
    typedef enum logic [1:0] {METRO_NOP, METRO_SELF, METRO_PREV, METRO_FOLW} metropolis_command_t;
    typedef enum logic [1:0] {EXCH_NOP, EXCH_PREV, EXCH_FOLW} exchange_command_t;
    // lower tile of a pair looks forward (FOLW), upper looks back (PREV); unpaired ends stay SELF
    function automatic role_t role_of(input int i, input int n, input logic parity);
        return (i[0] == parity) ? ((i + 1 < n) ? FOLW : SELF) : ((i > 0) ? PREV : SELF);
    endfunction
    function automatic exchange_command_t exch_of(input role_t r);
        return (r == FOLW) ? EXCH_FOLW : (r == PREV) ? EXCH_PREV : EXCH_NOP;
    endfunction
    function automatic metropolis_command_t metro_of(input role_t r);
        return (r == FOLW) ? METRO_FOLW : (r == PREV) ? METRO_PREV : METRO_SELF;
    endfunction
    function automatic logic [63:0] xorshift64(input logic [63:0] x);
        logic [63:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 7);
        return y ^ (y << 17);
    endfunction
endpackage

// File: rtl/replica_seq.sv
// replica_seq: iteration sequencer (FSM, phase counter, iteration count, parity, bank and stop latch)
module replica_seq import replica_pkg::*; #(
    parameter int ITER_W = 32,
    parameter int DIST_CYC = 4,
    parameter int METRO_CYC = 3,
    parameter int EXCH_CYC = CITY_NUM + 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [ITER_W-1:0] iter_num,
    output logic              busy,
    output logic              done,
    output logic [ITER_W-1:0] iter_count,
    output logic              parity,
    output logic              rbank,
    output logic              random_init,
    output logic              random_run,
    output logic              dist_run,
    output logic              metro_en,
    output logic              exch_en
);
    localparam int MAX_CYC = (DIST_CYC > METRO_CYC) ? ((DIST_CYC > EXCH_CYC) ? DIST_CYC : EXCH_CYC)
                                                    : ((METRO_CYC > EXCH_CYC) ? METRO_CYC : EXCH_CYC);
    localparam int PH_W = $clog2(MAX_CYC) + 1;
    state_t state, state_n;
    logic [PH_W-1:0] phase, phase_load;
    logic [ITER_W-1:0] iter_q;
    logic stop_q, last, finish;
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        last = phase == '0;
        finish = (iter_count + ITER_W'(1) == iter_q) || stop_q || stop;
        state_n = state;
        case (state)
            IDLE:    state_n = start ? SEED : IDLE;
            SEED:    state_n = (iter_q == '0) ? DONE : OPT;
            OPT:     state_n = DIST;
            DIST:    state_n = last ? METRO : DIST;
            METRO:   state_n = last ? EXCH : METRO;
            EXCH:    state_n = last ? (finish ? DONE : OPT) : EXCH;
            default: state_n = IDLE;
        endcase
        phase_load = (state_n == DIST) ? PH_W'(DIST_CYC - 1) :
                     (state_n == METRO) ? PH_W'(METRO_CYC - 1) :
                     (state_n == EXCH) ? PH_W'(EXCH_CYC - 1) : '0;
    end
    always_comb begin
        busy = state != IDLE && state != DONE;
        done = state == DONE;
        random_init = state == SEED;
        random_run = state == OPT;
        dist_run = state == DIST;
        metro_en = state == METRO;
        exch_en = state == EXCH;
    end
    // phase counter reloads on every state change and counts down to the last cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= '0;
            iter_count <= '0;
            iter_q <= '0;
            parity <= 1'b0;
            rbank <= 1'b0;
            stop_q <= 1'b0;
        end else begin
            phase <= (state_n != state) ? phase_load : phase - PH_W'(1);
            stop_q <= (state == DONE) ? 1'b0 : (state != IDLE) && (stop_q || stop);
            if (state == IDLE && start) begin
                iter_count <= '0;
                iter_q <= iter_num;
                parity <= 1'b0;
                rbank <= 1'b0;
            end
            if (state == EXCH && last) begin
                iter_count <= iter_count + ITER_W'(1);
                parity <= ~parity;
                rbank <= ~rbank;
            end
        end
    end
endmodule

// File: rtl/replica_tile.sv
// replica_tile: one replica with distance table, random source, double-banked tour total and neighbour exchange
module replica_tile import replica_pkg::*; (
    input  logic                clk,
    input  logic                reset,
    input  logic                random_init,
    input  logic [63:0]         random_seed,
    input  logic                random_run,
    input  logic                rbank,
    input  opt_command_t        opt_command,
    input  distance_command_t   c_distance,
    input  metropolis_command_t c_metropolis,
    input  exchange_command_t   c_exchange,
    input  logic                distance_write,
    input  distance_addr_t      distance_w_addr,
    input  distance_data_t      distance_w_data,
    input  total_data_t         prev_dis_data,
    input  logic                prev_valid,
    input  total_data_t         folw_dis_data,
    input  logic                folw_valid,
    output total_data_t         out_dis_data,
    output logic                out_valid
);
    distance_data_t dist_mem [CITY_NUM*CITY_NUM];
    total_data_t bank [2];
    total_data_t cand, prop;
    distance_addr_t addr;
    logic [63:0] lfsr;
    always_ff @(posedge clk) begin
        if (distance_write) dist_mem[distance_w_addr] <= distance_w_data;
    end
    // the shadow bank is primed at OPT so tiles that skip the exchange keep their own total
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= '0;
            bank[0] <= '0;
            bank[1] <= '0;
            cand <= '0;
            prop <= '0;
            addr <= '0;
            out_valid <= 1'b0;
        end else begin
            if (random_init) begin
                lfsr <= random_seed | 64'd1;
                out_valid <= 1'b1;
            end
            if (random_run) lfsr <= xorshift64(lfsr);
            if (opt_command == OPT_RUN) begin
                addr <= lfsr[CITY_NUM_LOG*2-1:0];
                bank[~rbank] <= bank[rbank];
            end
            if (c_distance == DIST_RUN) cand <= bank[rbank] + TOTAL_W'(dist_mem[addr]);
            prop <= (c_metropolis == METRO_FOLW) ? ((folw_valid && folw_dis_data < cand) ? folw_dis_data : cand) :
                    (c_metropolis == METRO_PREV) ? ((prev_valid && prev_dis_data > cand) ? prev_dis_data : cand) :
                    (c_metropolis == METRO_SELF) ? cand : prop;
            if (c_exchange != EXCH_NOP) bank[~rbank] <= prop;
        end
    end
    assign out_dis_data = bank[rbank];
endmodule

// File: rtl/replica_array.sv
// replica_array: sequencer plus a neighbour chain of replica tiles with even/odd exchange pairing
module replica_array import replica_pkg::*; #(
    parameter int REPLICA_NUM = 32,
    parameter int ITER_W = 32,
    parameter int DIST_CYC = 4,
    parameter int METRO_CYC = 3,
    parameter int EXCH_CYC = CITY_NUM + 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      stop,
    input  logic [ITER_W-1:0]         iter_num,
    input  logic [63:0]               random_seed,
    input  logic                      distance_write,
    input  logic [CITY_NUM_LOG*2-1:0] distance_w_addr,
    input  distance_data_t            distance_w_data,
    output logic                      busy,
    output logic                      done,
    output logic [ITER_W-1:0]         iter_count,
    output logic                      parity,
    output total_data_t               total_first,
    output total_data_t               total_last
);
    logic rbank, random_init, random_run, dist_run, metro_en, exch_en;
    opt_command_t opt_command;
    distance_command_t c_distance;
    role_t role [REPLICA_NUM];
    metropolis_command_t c_metropolis [REPLICA_NUM];
    exchange_command_t c_exchange [REPLICA_NUM];
    logic [63:0] tile_seed [REPLICA_NUM];
    total_data_t out_dis [REPLICA_NUM];
    logic out_valid [REPLICA_NUM];
    replica_seq #(
        .ITER_W(ITER_W), .DIST_CYC(DIST_CYC), .METRO_CYC(METRO_CYC), .EXCH_CYC(EXCH_CYC)
    ) u_seq (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .iter_num(iter_num),
        .busy(busy), .done(done), .iter_count(iter_count), .parity(parity), .rbank(rbank),
        .random_init(random_init), .random_run(random_run), .dist_run(dist_run),
        .metro_en(metro_en), .exch_en(exch_en)
    );
    assign opt_command = random_run ? OPT_RUN : OPT_NOP;
    assign c_distance = dist_run ? DIST_RUN : DIST_NOP;
    assign total_first = out_dis[0];
    assign total_last = out_dis[REPLICA_NUM-1];
    // chain ends loop back onto their own outputs with valid low
    for (genvar g = 0; g < REPLICA_NUM; g++) begin : g_tile
        assign role[g] = role_of(g, REPLICA_NUM, parity);
        assign c_metropolis[g] = metro_en ? metro_of(role[g]) : METRO_NOP;
        assign c_exchange[g] = exch_en ? exch_of(role[g]) : EXCH_NOP;
        assign tile_seed[g] = random_seed ^ 64'(g);
        replica_tile u_tile (
            .clk(clk), .reset(reset), .random_init(random_init), .random_seed(tile_seed[g]),
            .random_run(random_run), .rbank(rbank), .opt_command(opt_command),
            .c_distance(c_distance), .c_metropolis(c_metropolis[g]), .c_exchange(c_exchange[g]),
            .distance_write(distance_write), .distance_w_addr(distance_w_addr),
            .distance_w_data(distance_w_data),
            .prev_dis_data(out_dis[(g == 0) ? 0 : g - 1]),
            .prev_valid((g == 0) ? 1'b0 : out_valid[(g == 0) ? 0 : g - 1]),
            .folw_dis_data(out_dis[(g == REPLICA_NUM - 1) ? g : g + 1]),
            .folw_valid((g == REPLICA_NUM - 1) ? 1'b0 : out_valid[(g == REPLICA_NUM - 1) ? g : g + 1]),
            .out_dis_data(out_dis[g]), .out_valid(out_valid[g])
        );
    end
endmodule

// File: tb/tb_replica_array.sv
// tb_replica_array: cycle-timeline reference model of the sequencer and pairing, randomized runs
module tb_replica_array;
    import replica_pkg::*;
    localparam int N = 6, D = 4, M = 3, E = 10;
    typedef enum {P_IDLE, P_SEED, P_OPT, P_DIST, P_METRO, P_EXCH, P_DONE} ph_t;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, distance_write = 1'b0;
    logic busy, done, parity;
    logic [31:0] iter_num = '0, iter_count;
    logic [63:0] random_seed = '0;
    logic [5:0] distance_w_addr = '0;
    distance_data_t distance_w_data = '0;
    total_data_t total_first, total_last;
    int tests = 0, fails = 0;
    always #5 clk = ~clk;
    replica_array #(.REPLICA_NUM(N), .ITER_W(32), .DIST_CYC(D), .METRO_CYC(M), .EXCH_CYC(E)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .iter_num(iter_num),
        .random_seed(random_seed), .distance_write(distance_write),
        .distance_w_addr(distance_w_addr), .distance_w_data(distance_w_data),
        .busy(busy), .done(done), .iter_count(iter_count), .parity(parity),
        .total_first(total_first), .total_last(total_last)
    );
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic check_cycle(input ph_t ph, input int it, input bit par, input string tag);
        int rl [N];
        foreach (rl[i]) rl[i] = 0;
        for (int lo = int'(par); lo + 1 < N; lo += 2) begin
            rl[lo] = 1;
            rl[lo + 1] = 2;
        end
        check({tag, " busy"}, busy, (ph != P_IDLE && ph != P_DONE));
        check({tag, " done"}, done, ph == P_DONE);
        check({tag, " iter_count"}, iter_count, it);
        check({tag, " parity"}, parity, par);
        check({tag, " random_init"}, dut.random_init, ph == P_SEED);
        check({tag, " random_run"}, dut.random_run, ph == P_OPT);
        check({tag, " opt"}, dut.opt_command, (ph == P_OPT) ? OPT_RUN : OPT_NOP);
        check({tag, " dist"}, dut.c_distance, (ph == P_DIST) ? DIST_RUN : DIST_NOP);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s role%0d", tag, i), dut.role[i], (rl[i] == 1) ? FOLW : (rl[i] == 2) ? PREV : SELF);
            check($sformatf("%s metro%0d", tag, i), dut.c_metropolis[i],
                  (ph != P_METRO) ? METRO_NOP : (rl[i] == 1) ? METRO_FOLW : (rl[i] == 2) ? METRO_PREV : METRO_SELF);
            check($sformatf("%s exch%0d", tag, i), dut.c_exchange[i],
                  (ph != P_EXCH) ? EXCH_NOP : (rl[i] == 1) ? EXCH_FOLW : (rl[i] == 2) ? EXCH_PREV : EXCH_NOP);
        end
    endtask
    task automatic push(inout ph_t pq[$], inout int iq[$], inout bit bq[$], input ph_t ph, input int it, input int cnt);
        for (int j = 0; j < cnt; j++) begin
            pq.push_back(ph);
            iq.push_back(it);
            bq.push_back(it[0]);
        end
    endtask
    // stop_c/restart_c < 0 disable the pulse; restart lands at a random busy cycle
    task automatic run(input int n, input int stop_c, input bit restart, input logic [63:0] seed);
        ph_t pq[$];
        int iq[$];
        bit bq[$];
        int k = 0, restart_c = -1;
        bit fin = (n == 0);
        push(pq, iq, bq, P_IDLE, 0, 1);
        push(pq, iq, bq, P_SEED, 0, 1);
        while (!fin) begin
            push(pq, iq, bq, P_OPT, k, 1);
            push(pq, iq, bq, P_DIST, k, D);
            push(pq, iq, bq, P_METRO, k, M);
            push(pq, iq, bq, P_EXCH, k, E);
            fin = (k + 1 == n) || (stop_c >= 1 && stop_c <= pq.size() - 1);
            k++;
        end
        push(pq, iq, bq, P_DONE, k, 1);
        push(pq, iq, bq, P_IDLE, k, 1);
        if (restart) restart_c = $urandom_range(1, pq.size() - 3);
        iter_num = n;
        random_seed = seed;
        for (int c = 0; c < pq.size(); c++) begin
            @(negedge clk);
            if (c > 0) check_cycle(pq[c], iq[c], bq[c], $sformatf("n%0d c%0d", n, c));
            if (pq[c] == P_SEED) begin
                check("seed0", dut.tile_seed[0], seed);
                check("seed5", dut.tile_seed[5], seed ^ 64'd5);
            end
            start = (c == 0) || (c == restart_c);
            stop = (c == stop_c);
        end
        start = 1'b0;
        stop = 1'b0;
    endtask
    initial begin
        logic [5:0] a;
        logic [15:0] d;
        repeat (3) @(negedge clk);
        check_cycle(P_IDLE, 0, 0, "reset");
        check("reset total_first", total_first, 0);
        check("reset total_last", total_last, 0);
        reset = 1'b0;
        run(3, -1, 1'b0, 64'h1234);
        check("seed 0x1234 tile5", 64'h1234 ^ 64'd5, 64'h1231);
        run(0, -1, 1'b0, 64'h55);
        run(10, 20, 1'b1, 64'hdead_beef);
        check("stop iter_count", iter_count, 2);
        iter_num = 5;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_cycle(P_SEED, 0, 0, "rst seed");
        @(negedge clk);
        check_cycle(P_OPT, 0, 0, "rst opt");
        @(negedge clk);
        check_cycle(P_DIST, 0, 0, "rst dist");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_cycle(P_IDLE, 0, 0, "rst after");
        repeat (25) begin
            @(negedge clk);
            check_cycle(P_IDLE, 0, 0, "rst idle");
        end
        for (int w = 0; w < 4; w++) begin
            a = (w == 0) ? {3'd1, 3'd2} : 6'($urandom);
            d = 16'($urandom);
            @(negedge clk);
            distance_write = 1'b1;
            distance_w_addr = a;
            distance_w_data = d;
            @(negedge clk);
            distance_write = 1'b0;
            check("dist tile0", dut.g_tile[0].u_tile.dist_mem[a], d);
            check("dist tile5", dut.g_tile[5].u_tile.dist_mem[a], d);
        end
        for (int r = 0; r < 8; r++)
            run($urandom_range(0, 4), ($urandom_range(0, 2) == 0) ? $urandom_range(1, 70) : -1,
                1'($urandom), {$urandom, $urandom});
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
